serial_tx: RTL
==============

// Module: serial_tx
// PURPOSE
//   Parallel-in, serial-out frame transmitter built on edge-triggered flip-flops.
//   Latches a DATA_W-bit word on a start request.
//   Shifts the word out on one line as: start bit (0), data bits LSB first, stop bit (1).
//   Transmit end of the lab serial link; the matching receiver deserialises the same frame.
// PARAMETERS
//   DATA_W        8   width of the parallel data word (>=1)
//   CLKS_PER_BIT  4   clk cycles each serial bit is held on tx (>=1)
// PORTS
//   clk    in   1       rising-edge clock, single clock domain
//   reset  in   1       asynchronous, active-high reset
//   start  in   1       request to send data; sampled on posedge clk
//   data   in   DATA_W  word to transmit; captured when start is accepted
//   tx     out  1       serial line; idles high
//   busy   out  1       high while a frame is in progress
//   done   out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset (async, immediate, any state):
//     - state=IDLE, tx=1, busy=0, done=0, shift reg=0, bit/cycle counters=0.
//   Registers:
//     - All outputs are registered; no combinational path from inputs to outputs.
//     - Counters are sized $clog2 of their range, minimum 1 bit.
//   States: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE
//       - tx=1, busy=0.
//       - If start=1 at posedge: latch data, clear counters, go to START.
//       - busy=1 and tx=0 from that edge.
//     START
//       - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//     DATA
//       - tx=shreg[0] for CLKS_PER_BIT cycles, then shift right by one and increment the bit index.
//       - After bit DATA_W-1 is held its full time, go to STOP.
//     STOP
//       - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
//       - busy=0 and done=1 on the first IDLE cycle only.
//   Latency:
//     - Frame = (DATA_W+2)*CLKS_PER_BIT cycles from the accepting edge to the done edge.
//     - Accepting edge to tx falling: 0 cycles (same edge).
//   Boundary conditions:
//     - start while busy=1: ignored; no queueing. data changes mid-frame have no effect.
//     - start=1 in the cycle done=1: accepted (back-to-back frames).
//       The next start bit follows the stop bit with no idle gap.
//     - start held high continuously: frames repeat back-to-back; data is re-captured each time.
//     - CLKS_PER_BIT=1: every bit lasts exactly one cycle; the counter never wraps illegally.
//     - Counter wrap: the cycle counter resets to 0 at CLKS_PER_BIT-1 on every bit boundary.
//     - Reset asserted mid-frame: tx returns to 1 immediately, frame abandoned, done not pulsed.
//       After deassertion the block waits in IDLE for a new start.
// TESTING (DATA_W=8, CLKS_PER_BIT=4 unless noted)
//   1. Reset: reset=1 at t=1, released t=4
//      -> tx=1, busy=0, done=0 during and after, with no clk edge required.
//   2. Single frame: start 1-cycle pulse, data=8'hA5
//      -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//      -> busy high 40 cycles; done pulse on cycle 40.
//   3. Ignored start: second start with data=8'hFF on cycle 10 of an 8'h3C frame
//      -> tx carries only 8'h3C; exactly one done.
//   4. Back-to-back: start high with data=8'h01 and then 8'h80
//      -> 80 cycles of frames with no tx=1 gap; two done pulses 40 cycles apart.
//   5. Reset mid-frame: reset at cycle 15 of an 8'h55 frame
//      -> tx=1 and busy=0 immediately, no done; a following start of 8'h0F transmits correctly.
//   6. CLKS_PER_BIT=1, data=8'h96
//      -> tx = 0,0,1,1,0,1,0,0,1,1 on consecutive cycles; done on cycle 10.

Source files
------------

// File: rtl/serial_tx.sv
// Frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each held CLKS_PER_BIT clocks. Outputs tx/busy/done are all registered.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_n, busy_n, done_n;
  logic              bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = START;
          shreg_n   = data;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bit_idx == BIT_LAST) state_n = STOP;
          else                     bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n  = '0;
          done_n = 1'b1;
          // A start on the completing edge chains the next frame with no idle gap.
          if (start) begin
            state_n   = START;
            shreg_n   = data;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are derived from the next state so they register on the same edge.
    busy_n = (state_n != IDLE);
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
